// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences a multi-mic PDM capture into per-mic BRAMs.
// Holds the PDM clock generator and decimators in reset, releases them,
// discards decimator settling samples, then drives a shared BRAM port-B
// byte address / write enable. Single-shot or continuous ping-pong modes.
// Optional feature macro: CAPTURE_SEQ_TIMESTAMP_EN adds sample_count[31:0].
// RESET_CYCLES must be at least 1.
module capture_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned SETTLE_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic        half_ack,
    input  logic        sample_valid,
    output logic        clk_gen_rst,
    output logic        mic_rst,
    output logic [31:0] addr,
    output logic [3:0]  wen,
    output logic        busy,
    output logic        half_irq,
    output logic        full_irq,
    output logic        overrun
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
    ,
    output logic [31:0] sample_count
`endif
);

    localparam int unsigned ARM_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int unsigned CNT_W = (ARM_W > SET_W) ? ARM_W : SET_W;
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] HALF_LAST  = WORD_LAST >> 1;
    localparam logic [ADDR_WIDTH-1:0] HALF_FIRST = ~HALF_LAST;
    localparam bit SKIP_SETTLE = (SETTLE_SAMPLES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                  cont_q, cont_d;
    logic [1:0]            pend_q, pend_d;
    logic                  ack_ptr_q, ack_ptr_d;
    logic                  prev_start_q, prev_stop_q;
    logic                  rst_d;
    logic [31:0]           addr_d;
    logic [3:0]            wen_d;
    logic                  busy_d, half_d, full_d, ovr_d;
    logic                  start_edge_c, stop_edge_c;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
    logic [31:0]           sample_count_d;
`endif

    assign start_edge_c = start & ~prev_start_q;
    assign stop_edge_c  = stop & ~prev_stop_q;

    // Next-state, counters, ping-pong bookkeeping and registered output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        cont_d     = cont_q;
        pend_d     = pend_q;
        ack_ptr_d  = ack_ptr_q;
        rst_d      = clk_gen_rst;
        addr_d     = addr;
        wen_d      = 4'h0;
        busy_d     = busy;
        half_d     = 1'b0;
        full_d     = 1'b0;
        ovr_d      = overrun;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
        sample_count_d = sample_count;
`endif

        // Halves are acknowledged in the order they filled; acks with nothing pending are dropped
        if (half_ack && pend_q[ack_ptr_q]) begin
            pend_d[ack_ptr_q] = 1'b0;
            ack_ptr_d         = ~ack_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                rst_d  = 1'b1;
                busy_d = 1'b0;
                addr_d = '0;
                if (start_edge_c && !stop_edge_c) begin
                    state_d    = S_ARM;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    word_idx_d = '0;
                    cont_d     = continuous;
                    ovr_d      = 1'b0;
                    pend_d     = '0;
                    ack_ptr_d  = 1'b0;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
                    sample_count_d = '0;
`endif
                end
            end
            S_ARM: begin
                if (stop_edge_c) begin
                    state_d = S_DONE;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == ARM_LAST) begin
                    rst_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SKIP_SETTLE ? S_CAPTURE : S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (stop_edge_c) begin
                    state_d = S_DONE;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (sample_valid) begin
                    if (cnt_q == SET_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (stop_edge_c) begin
                    state_d = S_DONE;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (sample_valid) begin
                    wen_d      = 4'hF;
                    addr_d     = 32'({word_idx_q, 2'b00});
                    word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                    half_d     = (word_idx_q == HALF_LAST);
                    full_d     = (word_idx_q == WORD_LAST);
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
                    sample_count_d = sample_count + 32'd1;
`endif
                    // Entering a half the PS still owns: keep writing, flag it
                    if (cont_q && (((word_idx_q == '0) && pend_d[0]) ||
                                   ((word_idx_q == HALF_FIRST) && pend_d[1]))) begin
                        ovr_d = 1'b1;
                    end
                    if (half_d) pend_d[0] = 1'b1;
                    if (full_d) pend_d[1] = 1'b1;
                    if (full_d && !cont_q) begin
                        state_d = S_DONE;
                        rst_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rst_d   = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                rst_d   = 1'b1;
                busy_d  = 1'b0;
                addr_d  = '0;
            end
        endcase
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            word_idx_q   <= '0;
            cont_q       <= 1'b0;
            pend_q       <= '0;
            ack_ptr_q    <= 1'b0;
            prev_start_q <= 1'b1;
            prev_stop_q  <= 1'b1;
            clk_gen_rst  <= 1'b1;
            mic_rst      <= 1'b1;
            addr         <= '0;
            wen          <= 4'h0;
            busy         <= 1'b0;
            half_irq     <= 1'b0;
            full_irq     <= 1'b0;
            overrun      <= 1'b0;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
            sample_count <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_idx_q   <= word_idx_d;
            cont_q       <= cont_d;
            pend_q       <= pend_d;
            ack_ptr_q    <= ack_ptr_d;
            prev_start_q <= start;
            prev_stop_q  <= stop;
            clk_gen_rst  <= rst_d;
            mic_rst      <= rst_d;
            addr         <= addr_d;
            wen          <= wen_d;
            busy         <= busy_d;
            half_irq     <= half_d;
            full_irq     <= full_d;
            overrun      <= ovr_d;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
            sample_count <= sample_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus a randomized soak,
// all checked every cycle against a transaction-level reference model.
module tb_capture_sequencer;

    localparam int AW = 4;
    localparam int R  = 16;
    localparam int S  = 64;
    localparam int D  = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, continuous, half_ack, sample_valid;
    logic        clk_gen_rst, mic_rst;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic        busy, half_irq, full_irq, overrun;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
    logic [31:0] sample_count;
`endif

    capture_sequencer #(
        .ADDR_WIDTH    (AW),
        .RESET_CYCLES  (R),
        .SETTLE_SAMPLES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .half_ack    (half_ack),
        .sample_valid(sample_valid),
        .clk_gen_rst (clk_gen_rst),
        .mic_rst     (mic_rst),
        .addr        (addr),
        .wen         (wen),
        .busy        (busy),
        .half_irq    (half_irq),
        .full_irq    (full_irq),
        .overrun     (overrun)
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
        ,
        .sample_count(sample_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: session flags, counters since start, pending halves
    bit          m_busy, m_done, m_cont, m_ovr;
    int          m_cyc, m_npulse;
    logic [1:0]  m_pend;
    logic        m_ptr;
    logic [31:0] m_count;
    logic        b_prev_st, b_prev_sp;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic        e_half, e_full;

    logic cur_st, cur_sp, cur_ct;
    int   ack_wait;
    int   obs_wr, obs_half, obs_full;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_busy = 0; m_done = 0; m_cont = 0; m_ovr = 0;
        m_cyc = 0; m_npulse = 0; m_pend = 2'b00; m_ptr = 1'b0; m_count = '0;
        b_prev_st = 1'b1; b_prev_sp = 1'b1;
        e_wen = 4'h0; e_addr = '0; e_half = 1'b0; e_full = 1'b0;
        ack_wait = -1;
    endtask

    task automatic compare_all();
        logic e_rst;
        e_rst = m_busy ? (m_cyc < R) : 1'b1;
        check_eq("wen", 32'(wen), 32'(e_wen));
        check_eq("addr", addr, e_addr);
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("clk_gen_rst", 32'(clk_gen_rst), 32'(e_rst));
        check_eq("mic_rst", 32'(mic_rst), 32'(e_rst));
        check_eq("half_irq", 32'(half_irq), 32'(e_half));
        check_eq("full_irq", 32'(full_irq), 32'(e_full));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
        check_eq("sample_count", sample_count, m_count);
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, compare
    task automatic step(input logic sv, input logic ack, input logic st, input logic sp, input logic ct);
        logic st_e, sp_e;
        int   w, idx;
        start = st; stop = sp; sample_valid = sv; half_ack = ack; continuous = ct;
        st_e = st & ~b_prev_st;
        sp_e = sp & ~b_prev_sp;
        b_prev_st = st;
        b_prev_sp = sp;
        e_wen = 4'h0; e_half = 1'b0; e_full = 1'b0;
        if (ack && m_pend[m_ptr]) begin
            m_pend[m_ptr] = 1'b0;
            m_ptr = ~m_ptr;
        end
        if (m_done) begin
            m_done = 0;
            e_addr = '0;
        end else if (!m_busy) begin
            if (st_e && !sp_e) begin
                m_busy = 1; m_cyc = 0; m_npulse = 0; m_cont = ct; m_ovr = 0;
                m_pend = 2'b00; m_ptr = 1'b0; m_count = '0;
            end
        end else if (sp_e) begin
            m_busy = 0;
            m_done = 1;
        end else begin
            if (m_cyc >= R && sv) begin
                if (m_npulse < S) begin
                    m_npulse++;
                end else begin
                    w   = m_npulse - S;
                    idx = w % D;
                    e_wen  = 4'hF;
                    e_addr = 32'(idx * 4);
                    e_half = (idx == D / 2 - 1);
                    e_full = (idx == D - 1);
                    if (m_cont && ((idx == 0 && m_pend[0]) || (idx == D / 2 && m_pend[1])))
                        m_ovr = 1;
                    if (e_half) m_pend[0] = 1'b1;
                    if (e_full) m_pend[1] = 1'b1;
                    m_count = m_count + 32'd1;
                    m_npulse++;
                    if (e_full && !m_cont) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
            m_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (wen == 4'hF) obs_wr++;
        if (half_irq) obs_half++;
        if (full_irq) obs_full++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_st, cur_sp, cur_ct);
    endtask

    // Start edge followed by the reset-hold window
    task automatic begin_capture(input logic ct);
        cur_ct = ct;
        cur_st = 1'b0;
        cur_sp = 1'b0;
        idle_steps(1);
        cur_st = 1'b1;
        idle_steps(1 + R);
        obs_wr = 0; obs_half = 0; obs_full = 0;
    endtask

    // Random-gap pulses until the model has seen target pulses or capture ends
    task automatic run_pulses(input int target, input bit acks);
        int guard;
        bit a;
        guard = 0;
        while (m_npulse < target && m_busy && guard < 4000) begin
            a = acks && (ack_wait == 0);
            step($urandom_range(0, 2) != 0, a, cur_st, cur_sp, cur_ct);
            if (ack_wait >= 0) ack_wait--;
            if (e_half || e_full) ack_wait = $urandom_range(0, 2);
            guard++;
        end
        check_eq("pulse_budget", 32'(guard < 4000), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; continuous = 1'b0; half_ack = 1'b0; sample_valid = 1'b0;
        cur_st = 1'b0; cur_sp = 1'b0; cur_ct = 1'b0;
        obs_wr = 0; obs_half = 0; obs_full = 0;
        reset_model();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;
        compare_all();
        idle_steps(3);

        // Single-shot: reset window, 70 pulses -> 6 writes, stop coincident with a pulse
        begin_capture(1'b0);
        run_pulses(70, 1'b0);
        check_eq("A_writes", 32'(obs_wr), 32'd6);
        check_eq("A_last_addr", addr, 32'h14);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("stop_no_wen", 32'(wen), 32'h0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_rst", 32'(clk_gen_rst), 32'd1);
        cur_sp = 1'b1;
        idle_steps(2);
        check_eq("idle_addr", addr, 32'h0);

        // Single-shot fill of all 16 words
        begin_capture(1'b0);
        run_pulses(S + D + 10, 1'b0);
        check_eq("C_writes", 32'(obs_wr), 32'(D));
        check_eq("C_half_cnt", 32'(obs_half), 32'd1);
        check_eq("C_full_cnt", 32'(obs_full), 32'd1);
        idle_steps(2);
        check_eq("C_idle_busy", 32'(busy), 32'd0);

        // Continuous without acknowledges: overrun after wrap
        begin_capture(1'b1);
        run_pulses(S + 24, 1'b0);
        check_eq("D_overrun", 32'(overrun), 32'd1);
        check_eq("D_busy", 32'(busy), 32'd1);
        cur_sp = 1'b1;
        idle_steps(3);

        // Continuous with prompt acknowledges: no overrun over 64 writes
        begin_capture(1'b1);
        ack_wait = -1;
        run_pulses(S + 64, 1'b1);
        check_eq("E_overrun", 32'(overrun), 32'd0);
        check_eq("E_writes", 32'(obs_wr), 32'd64);

        // Simultaneous start and stop edges from idle: stop wins
        cur_sp = 1'b1;
        idle_steps(3);
        cur_st = 1'b0; cur_sp = 1'b0;
        idle_steps(1);
        cur_st = 1'b1; cur_sp = 1'b1;
        idle_steps(2);
        check_eq("startstop_busy", 32'(busy), 32'd0);
        cur_st = 1'b0; cur_sp = 1'b0;
        idle_steps(1);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) cur_st = ~cur_st;
            if ($urandom_range(0, 179) == 0) cur_sp = ~cur_sp;
            cur_ct = 1'($urandom_range(0, 1));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, cur_st, cur_sp, cur_ct);
        end

        // Asynchronous reset mid-capture with a half-boundary pulse in flight
        cur_sp = 1'b1;
        idle_steps(2);
        begin_capture(1'b1);
        run_pulses(S + D / 2 - 1, 1'b0);
        sample_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        reset_model();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        compare_all();
        rst = 1'b0;
        cur_st = 1'b0; cur_sp = 1'b0;
        idle_steps(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
